rcv_dqfifo_wptr_ctrl: RTL

RCV_DQFIFO_WPTR_CTRL -- requirements
Module: rcv_dqfifo_wptr_ctrl

---
 rtl/rcv_dqfifo_pkg.sv | 24 ++
 rtl/rcv_dqfifo_sync_vec.sv | 25 ++
 rtl/rcv_dqfifo_wptr_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/rcv_dqfifo_pkg.sv
// rtl/rcv_dqfifo_pkg.sv - shared pointer helpers for the receive data-queue FIFO
package rcv_dqfifo_pkg;

    // Widest pointer supported (ADDR_WIDTH up to 12); helpers operate zero-extended.
    localparam int MAX_PW = 13;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] g);
        logic [MAX_PW-1:0] b;
        b[MAX_PW-1] = g[MAX_PW-1];
        for (int i = MAX_PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rcv_dqfifo_sync_vec.sv
// rtl/rcv_dqfifo_sync_vec.sv - multi-flop CDC synchronizer for a Gray-coded vector
module rcv_dqfifo_sync_vec #(
    parameter int WIDTH  = 9,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // CDC synchronizer chain: i_d is asynchronous and feeds the first flop directly.
    logic [STAGES-1:0][WIDTH-1:0] r_cdc_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cdc_sync <= '0;
        end else begin
            r_cdc_sync <= {r_cdc_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_cdc_sync[STAGES-1];

endmodule

// File: rtl/rcv_dqfifo_wptr_ctrl.sv
// rtl/rcv_dqfifo_wptr_ctrl.sv - write-side pointer, full/level and overflow control
module rcv_dqfifo_wptr_ctrl
    import rcv_dqfifo_pkg::*;
#(
    parameter int  ADDR_WIDTH   = 8,
    parameter int  SYNC_STAGES  = 2,
    parameter int  AFULL_THRESH = (1 << ADDR_WIDTH) - 4,
    localparam int PW           = ptr_width(ADDR_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [PW-1:0]         i_rd_gptr,
    input  logic                  i_ovf_clr,
    output logic [ADDR_WIDTH-1:0] o_count,
    output logic [PW-1:0]         o_gcount,
    output logic [PW-1:0]         o_next_gcount,
    output logic                  o_wr_ack,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic [PW-1:0]         o_level,
    output logic                  o_overflow
);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gcount;
    logic [PW-1:0] r_level;
    logic          r_full;
    logic          r_afull;
    logic          r_overflow;

    logic [PW-1:0] w_rd_gsync;
    logic [PW-1:0] w_rd_bsync;
    logic [PW-1:0] w_next_bin;
    logic [PW-1:0] w_next_gray;
    logic [PW-1:0] w_next_level;
    logic          w_wr_ack;
    logic          w_full;
    logic          w_afull;

    rcv_dqfifo_sync_vec #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rd_gptr_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rd_gptr),
        .o_q     (w_rd_gsync)
    );

    assign w_wr_ack     = i_en & ~r_full;
    assign w_next_bin   = r_bin + PW'(w_wr_ack);
    assign w_next_gray  = PW'(bin2gray(MAX_PW'(w_next_bin)));
    assign w_rd_bsync   = PW'(gray2bin(MAX_PW'(w_rd_gsync)));
    assign w_next_level = w_next_bin - w_rd_bsync;
    assign w_afull      = (w_next_level >= PW'(AFULL_THRESH));

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign w_full = (w_next_gray == {~w_rd_gsync[PW-1:PW-2], w_rd_gsync[PW-3:0]});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bin      <= '0;
            r_gcount   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_bin      <= w_next_bin;
            r_gcount   <= w_next_gray;
            r_level    <= w_next_level;
            r_full     <= w_full;
            r_afull    <= w_afull;
            r_overflow <= (i_en & r_full) | (r_overflow & ~i_ovf_clr);
        end
    end

    assign o_count       = r_bin[ADDR_WIDTH-1:0];
    assign o_gcount      = r_gcount;
    assign o_next_gcount = w_next_gray;
    assign o_wr_ack      = w_wr_ack;
    assign o_full        = r_full;
    assign o_almost_full = r_afull;
    assign o_level       = r_level;
    assign o_overflow    = r_overflow;

endmodule
